// File: rtl/gate_checker.sv
// Self-test sequencer for an 8-gate bank: drives each a/b vector,
// waits for it to settle, and accumulates per-gate mismatch flags.
module gate_checker #(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] obs,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_mask,
   output logic [2:0] err_count
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYC - 1);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic [1:0] vec_q;
   logic [1:0] vec_d;
   logic       pass_d;
   logic [7:0] mask_d;
   logic [2:0] err_d;
   logic [7:0] exp_v;
   logic [7:0] mism;
   logic       a;
   logic       b;

   assign a = vec_q[1];
   assign b = vec_q[0];

   assign a_out = a;
   assign b_out = b;
   assign busy  = (state_q == SETTLE) || (state_q == CHECK);
   assign done  = (state_q == DONE);

   // Bit order: XNOR NOR NAND NOT XOR OR AND BUF
   assign exp_v = {~(a ^ b), ~(a | b), ~(a & b), ~b,
                   a ^ b, a | b, a & b, a};
   assign mism  = obs ^ exp_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         vec_q     <= '0;
         pass      <= 1'b0;
         fail_mask <= '0;
         err_count <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         vec_q     <= vec_d;
         pass      <= pass_d;
         fail_mask <= mask_d;
         err_count <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      pass_d  = pass;
      mask_d  = fail_mask;
      err_d   = err_count;
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = SETTLE;
               cnt_d   = '0;
               vec_d   = 2'b00;
               pass_d  = 1'b0;
               mask_d  = '0;
               err_d   = '0;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
               vec_d   = 2'b00;
               pass_d  = 1'b0;
            end else if (cnt_q == LAST_CNT) begin
               state_d = CHECK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         CHECK: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
               vec_d   = 2'b00;
               pass_d  = 1'b0;
            end else begin
               mask_d = fail_mask | mism;
               // At most four vectors, so saturation is a safety net
               if ((|mism) && (err_count != 3'd4))
                  err_d = err_count + 3'd1;
               if (vec_q == 2'b11) begin
                  state_d = DONE;
                  pass_d  = (mask_d == 8'h00);
               end else begin
                  state_d = SETTLE;
                  vec_d   = vec_q + 2'd1;
                  cnt_d   = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            vec_d   = 2'b00;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
